pc_next_unit: RTL and testbench

Parametrised next-PC unit for the multicycle CPU. It merges the next-PC source selection with the PC register, the EPC register and exception/return sequencing into one clocked block. It selects one of NUM_SRC candidate addresses and commits it on unconditional or conditional write. It vectors to a handler on exception request or misaligned target, and restores EPC on return. It sits between the ALU/shift-left-2/EPC datapath and the instruction memory address port, driven by the control unit.

---
 rtl/pc_next_unit_if.sv | 33 +++
 rtl/pc_next_unit.sv | 114 +++++++++++
 tb/tb_pc_next_unit.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/pc_next_unit_if.sv
// Control/datapath bundle for the next-PC unit: candidate addresses and commands in, PC state out.
// Commands are level signals sampled at every rising edge; there is no valid/ready backpressure.
interface pc_next_unit_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_SRC = 4
);
  localparam int SEL_W = $clog2(NUM_SRC);

  logic [NUM_SRC*WIDTH-1:0] srcIn;
  logic [SEL_W-1:0]         srcSel;
  logic                     pcWrite;
  logic                     pcWriteCond;
  logic                     condTrue;
  logic                     excReq;
  logic [1:0]               excCause;
  logic                     eret;
  logic [WIDTH-1:0]         pc;
  logic [WIDTH-1:0]         epc;
  logic [1:0]               cause;
  logic                     inExc;
  logic                     fault;
  logic                     selErr;

  modport master (
    output srcIn, srcSel, pcWrite, pcWriteCond, condTrue, excReq, excCause, eret,
    input  pc, epc, cause, inExc, fault, selErr
  );

  modport slave (
    input  srcIn, srcSel, pcWrite, pcWriteCond, condTrue, excReq, excCause, eret,
    output pc, epc, cause, inExc, fault, selErr
  );
endinterface

// File: rtl/pc_next_unit.sv
// Next-PC unit: source select, PC/EPC registers and exception/return/double-fault sequencing.
// All outputs are registered; state_dbg exposes the sequencing state.
module pc_next_unit #(
  parameter int               WIDTH       = 32,
  parameter int               NUM_SRC     = 4,
  parameter logic [WIDTH-1:0] RESET_PC    = '0,
  parameter logic [WIDTH-1:0] EXC_BASE    = 32'h0000_00FF,
  parameter int               VEC_STRIDE  = 4,
  parameter logic [1:0]       ALIGN_CAUSE = 2'd3
) (
  input  logic                clk,
  input  logic                reset,
  pc_next_unit_if.slave       bus,
  output logic [1:0]          state_dbg
);
  localparam int SEL_W = $clog2(NUM_SRC);

  typedef enum logic [1:0] {
    ST_NORMAL = 2'd0,
    ST_EXC    = 2'd1,
    ST_FAULT  = 2'd2
  } state_t;

  state_t           state_q, state_n;
  logic [WIDTH-1:0] pc_q, pc_n;
  logic [WIDTH-1:0] epc_q, epc_n;
  logic [1:0]       cause_q, cause_n;
  logic             fault_q, fault_n;
  logic             selerr_q, selerr_n;

  logic [WIDTH-1:0] cand;
  logic             sel_ok;
  logic             wr;
  logic             mis;

  function automatic logic [WIDTH-1:0] vec(input logic [1:0] c);
    return EXC_BASE + WIDTH'(c) * WIDTH'(VEC_STRIDE);
  endfunction

  // Out-of-range selects leave sel_ok low instead of reading past srcIn.
  always_comb begin
    cand   = '0;
    sel_ok = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (bus.srcSel == SEL_W'(k)) begin
        cand   = bus.srcIn[k*WIDTH +: WIDTH];
        sel_ok = 1'b1;
      end
    end
  end

  assign wr  = bus.pcWrite | (bus.pcWriteCond & bus.condTrue);
  assign mis = wr & sel_ok & (cand[1:0] != 2'b00);

  always_comb begin
    state_n  = state_q;
    pc_n     = pc_q;
    epc_n    = epc_q;
    cause_n  = cause_q;
    fault_n  = fault_q;
    selerr_n = 1'b0;
    case (state_q)
      ST_NORMAL, ST_EXC: begin
        if (bus.excReq || mis) begin
          if (state_q == ST_EXC) begin
            // Second exception inside the handler: park on the fault vector, keep epc/cause.
            state_n = ST_FAULT;
            fault_n = 1'b1;
            pc_n    = vec(ALIGN_CAUSE);
          end else begin
            state_n = ST_EXC;
            epc_n   = pc_q;
            cause_n = bus.excReq ? bus.excCause : ALIGN_CAUSE;
            pc_n    = vec(bus.excReq ? bus.excCause : ALIGN_CAUSE);
          end
        end else if (bus.eret && state_q == ST_EXC) begin
          state_n = ST_NORMAL;
          pc_n    = epc_q;
        end else if (wr) begin
          if (sel_ok) pc_n = cand;
          else        selerr_n = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_NORMAL;
      pc_q     <= RESET_PC;
      epc_q    <= '0;
      cause_q  <= 2'd0;
      fault_q  <= 1'b0;
      selerr_q <= 1'b0;
    end else begin
      state_q  <= state_n;
      pc_q     <= pc_n;
      epc_q    <= epc_n;
      cause_q  <= cause_n;
      fault_q  <= fault_n;
      selerr_q <= selerr_n;
    end
  end

  assign bus.pc     = pc_q;
  assign bus.epc    = epc_q;
  assign bus.cause  = cause_q;
  assign bus.fault  = fault_q;
  assign bus.selErr = selerr_q;
  assign bus.inExc  = (state_q != ST_NORMAL);
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_pc_next_unit.sv
// Directed bench for pc_next_unit: a 4-source instance for the main flow, a 3-source one for select errors.
module tb_pc_next_unit;
  logic       clk;
  logic       reset;
  logic [1:0] state_a;
  logic [1:0] state_b;
  int         n_tests;
  int         n_fail;

  pc_next_unit_if #(.WIDTH(32), .NUM_SRC(4)) bus_a ();
  pc_next_unit_if #(.WIDTH(32), .NUM_SRC(3)) bus_b ();

  pc_next_unit #(.WIDTH(32), .NUM_SRC(4)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_a.slave),
    .state_dbg (state_a)
  );

  pc_next_unit #(.WIDTH(32), .NUM_SRC(3)) u_dut3 (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus_b.slave),
    .state_dbg (state_b)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    bus_a.pcWrite     = 1'b0;
    bus_a.pcWriteCond = 1'b0;
    bus_a.condTrue    = 1'b0;
    bus_a.excReq      = 1'b0;
    bus_a.excCause    = 2'd0;
    bus_a.eret        = 1'b0;
  endtask

  task automatic set_src(input int k, input logic [31:0] v);
    bus_a.srcIn[k*32 +: 32] = v;
  endtask

  // one-cycle unconditional write of source k holding v
  task automatic jump(input int k, input logic [31:0] v);
    set_src(k, v);
    bus_a.srcSel  = 2'(k);
    bus_a.pcWrite = 1'b1;
    step();
    idle_a();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    idle_a();
    bus_a.srcIn  = '0;
    bus_a.srcSel = '0;
    bus_b.srcIn  = '0;
    bus_b.srcSel = '0;
    bus_b.pcWrite = 1'b0; bus_b.pcWriteCond = 1'b0; bus_b.condTrue = 1'b0;
    bus_b.excReq  = 1'b0; bus_b.excCause    = 2'd0; bus_b.eret     = 1'b0;
    do_reset();

    check("rst_pc",     bus_a.pc, 32'h0);
    check("rst_epc",    bus_a.epc, 32'h0);
    check("rst_cause",  32'(bus_a.cause), 32'h0);
    check("rst_inexc",  32'(bus_a.inExc), 32'h0);
    check("rst_fault",  32'(bus_a.fault), 32'h0);
    check("rst_selerr", 32'(bus_a.selErr), 32'h0);

    jump(1, 32'h40);
    check("write_pc", bus_a.pc, 32'h40);

    // conditional branch, not taken then taken
    set_src(2, 32'h80);
    bus_a.srcSel = 2'd2; bus_a.pcWriteCond = 1'b1; bus_a.condTrue = 1'b0;
    step();
    check("cond_nt_pc", bus_a.pc, 32'h40);
    bus_a.condTrue = 1'b1;
    step();
    idle_a();
    check("cond_t_pc", bus_a.pc, 32'h80);

    // exception with cause 1, then return
    jump(0, 32'h100);
    check("pre_exc_pc", bus_a.pc, 32'h100);
    bus_a.excReq = 1'b1; bus_a.excCause = 2'd1;
    step();
    idle_a();
    check("exc_pc",    bus_a.pc, 32'h103);
    check("exc_epc",   bus_a.epc, 32'h100);
    check("exc_cause", 32'(bus_a.cause), 32'h1);
    check("exc_inexc", 32'(bus_a.inExc), 32'h1);
    check("exc_state", 32'(state_a), 32'h1);
    bus_a.eret = 1'b1;
    step();
    idle_a();
    check("eret_pc",    bus_a.pc, 32'h100);
    check("eret_inexc", 32'(bus_a.inExc), 32'h0);

    // eret outside the handler is ignored
    bus_a.eret = 1'b1;
    step();
    idle_a();
    check("eret_norm_pc",    bus_a.pc, 32'h100);
    check("eret_norm_inexc", 32'(bus_a.inExc), 32'h0);

    // misaligned jump vectors to EXC_BASE + 3*4
    jump(3, 32'h20);
    check("pre_mis_pc", bus_a.pc, 32'h20);
    jump(3, 32'h22);
    check("mis_pc",    bus_a.pc, 32'h10B);
    check("mis_epc",   bus_a.epc, 32'h20);
    check("mis_cause", 32'(bus_a.cause), 32'h3);
    check("mis_inexc", 32'(bus_a.inExc), 32'h1);

    // aligned write inside the handler behaves normally
    jump(0, 32'h200);
    check("hnd_pc",    bus_a.pc, 32'h200);
    check("hnd_inexc", 32'(bus_a.inExc), 32'h1);

    // double fault
    bus_a.excReq = 1'b1; bus_a.excCause = 2'd2;
    step();
    idle_a();
    check("df_fault", 32'(bus_a.fault), 32'h1);
    check("df_pc",    bus_a.pc, 32'h10B);
    check("df_epc",   bus_a.epc, 32'h20);
    check("df_cause", 32'(bus_a.cause), 32'h3);
    check("df_state", 32'(state_a), 32'h2);
    set_src(0, 32'h300);
    bus_a.srcSel = 2'd0; bus_a.pcWrite = 1'b1; bus_a.eret = 1'b1; bus_a.excReq = 1'b1;
    step();
    idle_a();
    check("df_hold_pc",    bus_a.pc, 32'h10B);
    check("df_hold_fault", 32'(bus_a.fault), 32'h1);

    // reset clears the fault
    do_reset();
    check("rst2_pc",    bus_a.pc, 32'h0);
    check("rst2_fault", 32'(bus_a.fault), 32'h0);
    check("rst2_inexc", 32'(bus_a.inExc), 32'h0);
    check("rst2_epc",   bus_a.epc, 32'h0);

    // exception beats a same-cycle write; epc is the pre-write pc
    jump(1, 32'h40);
    set_src(0, 32'h200);
    bus_a.srcSel = 2'd0; bus_a.pcWrite = 1'b1; bus_a.excReq = 1'b1; bus_a.excCause = 2'd0;
    step();
    idle_a();
    check("excwr_pc",    bus_a.pc, 32'hFF);
    check("excwr_epc",   bus_a.epc, 32'h40);
    check("excwr_cause", 32'(bus_a.cause), 32'h0);

    // excReq together with eret in the handler faults
    bus_a.excReq = 1'b1; bus_a.excCause = 2'd1; bus_a.eret = 1'b1;
    step();
    idle_a();
    check("exceret_fault", 32'(bus_a.fault), 32'h1);
    check("exceret_pc",    bus_a.pc, 32'h10B);
    check("exceret_epc",   bus_a.epc, 32'h40);
    check("exceret_cause", 32'(bus_a.cause), 32'h0);

    // reset overrides simultaneous commands
    reset = 1'b1; bus_a.excReq = 1'b1; bus_a.pcWrite = 1'b1;
    step();
    reset = 1'b0;
    idle_a();
    check("rst_ovr_pc",    bus_a.pc, 32'h0);
    check("rst_ovr_fault", 32'(bus_a.fault), 32'h0);
    check("rst_ovr_inexc", 32'(bus_a.inExc), 32'h0);

    // select error on the 3-source instance
    bus_b.srcIn[1*32 +: 32] = 32'h40;
    bus_b.srcSel = 2'd1; bus_b.pcWrite = 1'b1;
    step();
    check("b_pc", bus_b.pc, 32'h40);
    bus_b.srcSel = 2'd3;
    step();
    bus_b.pcWrite = 1'b0;
    check("b_selerr_hi", 32'(bus_b.selErr), 32'h1);
    check("b_selerr_pc", bus_b.pc, 32'h40);
    step();
    check("b_selerr_lo", 32'(bus_b.selErr), 32'h0);
    check("b_pc_hold",   bus_b.pc, 32'h40);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
